// File: rtl/ycr1_tcm_bist.sv
// March-test initiator for the TCM data port: W0 -> R0 -> W1 -> R1 over BIST_WORDS words.
// Optional first-failure log enabled by defining YCR1_TCM_BIST_ERRLOG_EN.
module ycr1_tcm_bist #(
   parameter logic [31:0] BIST_BASE  = 32'h0000_0000,
   parameter int          BIST_WORDS = 1024,
   parameter logic [31:0] BIST_PATN  = 32'hA5A5_5A5A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] fail_cnt,
   output logic [31:0] err_addr,
   output logic [31:0] err_data,
   output logic        dmem_req,
   output logic        dmem_cmd,
   output logic [1:0]  dmem_width,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_req_ack,
   input  logic [31:0] dmem_rdata,
   input  logic [1:0]  dmem_resp
);

   localparam int               IDX_W    = $clog2(BIST_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIST_WORDS - 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_W0   = 3'd1;
   localparam logic [2:0] ST_R0   = 3'd2;
   localparam logic [2:0] ST_W1   = 3'd3;
   localparam logic [2:0] ST_R1   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic [1:0] RESP_NOTRDY = 2'b00;
   localparam logic [1:0] RESP_RDY_OK = 2'b01;
   localparam logic [1:0] RESP_RDY_ER = 2'b10;
   localparam logic [1:0] WIDTH_WORD  = 2'b10;

   logic [2:0]       r_state;
   logic             r_wait;
   logic [IDX_W-1:0] r_idx;
   logic [15:0]      r_fail_cnt;

   logic        w_access;
   logic        w_write;
   logic        w_read;
   logic        w_inv;
   logic [31:0] w_data;
   logic [31:0] w_exp;
   logic        w_resp_vld;
   logic        w_fail;
   logic        w_last;
   logic        w_launch;

   assign w_access   = (r_state == ST_W0) || (r_state == ST_R0) ||
                       (r_state == ST_W1) || (r_state == ST_R1);
   assign w_write    = (r_state == ST_W0) || (r_state == ST_W1);
   assign w_read     = (r_state == ST_R0) || (r_state == ST_R1);
   assign w_inv      = (r_state == ST_W1) || (r_state == ST_R1);
   assign w_data     = BIST_PATN ^ 32'(r_idx);
   // Same value serves as write data in W phases and as read expectation in R phases.
   assign w_exp      = w_inv ? ~w_data : w_data;
   assign w_resp_vld = w_access && r_wait && (dmem_resp != RESP_NOTRDY);
   assign w_fail     = w_resp_vld && ((dmem_resp == RESP_RDY_ER) ||
                       (w_read && (dmem_resp == RESP_RDY_OK) && (dmem_rdata != w_exp)));
   assign w_last     = (r_state == ST_R1) ? (r_idx == '0) : (r_idx == LAST_IDX);
   assign w_launch   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   assign busy       = w_access;
   assign done       = (r_state == ST_DONE);
   assign pass       = done && (r_fail_cnt == 16'd0);
   assign fail_cnt   = r_fail_cnt;
   assign dmem_req   = w_access && !r_wait;
   assign dmem_cmd   = w_write;
   assign dmem_width = WIDTH_WORD;
   assign dmem_addr  = w_access ? (BIST_BASE + (32'(r_idx) << 2)) : 32'd0;
   assign dmem_wdata = w_write ? w_exp : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_wait     <= 1'b0;
         r_idx      <= '0;
         r_fail_cnt <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_launch) begin
                  r_state    <= ST_W0;
                  r_wait     <= 1'b0;
                  r_idx      <= '0;
                  r_fail_cnt <= 16'd0;
               end
            end
            ST_W0, ST_R0, ST_W1, ST_R1: begin
               if (!r_wait) begin
                  if (dmem_req_ack) r_wait <= 1'b1;
               end else if (w_resp_vld) begin
                  r_wait <= 1'b0;
                  if (w_fail && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 16'd1;
                  if (w_last) begin
                     case (r_state)
                        ST_W0:   begin r_state <= ST_R0; r_idx <= '0;       end
                        ST_R0:   begin r_state <= ST_W1; r_idx <= '0;       end
                        ST_W1:   begin r_state <= ST_R1; r_idx <= LAST_IDX; end
                        default: begin r_state <= ST_DONE; r_idx <= '0;     end
                     endcase
                  end else if (r_state == ST_R1) begin
                     r_idx <= r_idx - 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef YCR1_TCM_BIST_ERRLOG_EN
   logic [31:0] r_err_addr;
   logic [31:0] r_err_data;

   // A zero fail count means the current response is the first failure of this run.
   always_ff @(posedge clk) begin
      if (rst || w_launch) begin
         r_err_addr <= 32'd0;
         r_err_data <= 32'd0;
      end else if (w_fail && (r_fail_cnt == 16'd0)) begin
         r_err_addr <= dmem_addr;
         r_err_data <= dmem_rdata;
      end
   end

   assign err_addr = r_err_addr;
   assign err_data = r_err_data;
`else
   assign err_addr = 32'd0;
   assign err_data = 32'd0;
`endif

endmodule
